// File: rtl/icu_sequencer_pkg.sv
// Shared ICU opcode and sequencer state definitions.
// Optional call stack selected by ICU_CALL_STACK_EN (see icu_sequencer).
package instructions;

  localparam int unsigned OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    NOPO = 4'h0, LD   = 4'h1, LDC  = 4'h2, AND  = 4'h3,
    ANDC = 4'h4, OR   = 4'h5, ORC  = 4'h6, XNOR = 4'h7,
    STO  = 4'h8, STOC = 4'h9, IEN  = 4'hA, OEN  = 4'hB,
    JMP  = 4'hC, RTN  = 4'hD, SKZ  = 4'hE, NOPF = 4'hF
  } instruction_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_MEM, S_REQ, S_DROP, S_EXEC
  } seq_state_t;

endpackage

// File: rtl/icu_sequencer_call_stack.sv
// Return-address LIFO for the ICU sequencer, built only when ICU_CALL_STACK_EN is defined.
// Pushes when full and pops when empty are ignored; the caller flags them.
module icu_call_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Entry 0 is always the top of stack, so no count-indexed read is needed.
  logic [DEPTH*WIDTH-1:0] r_mem;
  logic [CNT_W-1:0]       r_count;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_top   = r_mem[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_push && !o_full) begin
      r_count <= r_count + CNT_W'(1);
    end else if (i_pop && !o_empty) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !o_full) begin
      r_mem <= {r_mem[(DEPTH-1)*WIDTH-1:0], i_data};
    end else if (i_pop && !o_empty) begin
      r_mem <= {{WIDTH{1'b0}}, r_mem[DEPTH*WIDTH-1:WIDTH]};
    end
  end

endmodule

// File: rtl/icu_sequencer.sv
// Program sequencer for the ICU 1-bit core: ROM fetch, 4-phase req/ack, next-pc.
// Define ICU_CALL_STACK_EN to build the NOPF+JMP call / RTN return stack.
module icu_sequencer
  import instructions::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  output logic                       prog_en,
  output logic [ADDR_W-1:0]          prog_addr,
  input  logic [OPCODE_W+ADDR_W-1:0] prog_data,
  output logic                       icu_req,
  input  logic                       icu_ack,
  output logic [OPCODE_W-1:0]        icu_instruction,
  output logic [ADDR_W-1:0]          io_addr,
  input  logic                       icu_jmp,
  input  logic                       icu_rtn,
  input  logic                       icu_flag_o,
  input  logic                       icu_flag_f,
  output logic                       halted,
  output logic                       stack_err
);

  seq_state_t         r_state, w_next_state;
  logic [ADDR_W-1:0]  r_pc, w_pc_next, w_pc_inc;
  instruction_t       r_ir_op;
  logic [ADDR_W-1:0]  r_ir_operand;
  logic               r_req;
  logic               r_run_q, r_run_qq;
  logic               r_ack_meta, r_ack_sync;
  logic               w_run_rise;

`ifdef ICU_CALL_STACK_EN
  logic               r_call_pending, r_stack_err;
  logic               w_push, w_pop, w_stack_full, w_stack_empty;
  logic [ADDR_W-1:0]  w_stack_top;
`endif

  // Run history resets high so a level held through reset is not taken as an edge.
  assign w_run_rise = r_run_q & ~r_run_qq;
  assign w_pc_inc   = r_pc + ADDR_W'(1);

  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
`ifdef ICU_CALL_STACK_EN
    w_push       = 1'b0;
    w_pop        = 1'b0;
`endif
    case (r_state)
      S_IDLE:  if (w_run_rise) w_next_state = S_FETCH;
      S_FETCH: w_next_state = S_MEM;
      S_MEM:   w_next_state = S_REQ;
      S_REQ:   if (r_ack_sync) w_next_state = S_DROP;
      S_DROP:  if (!r_ack_sync) w_next_state = S_EXEC;
      S_EXEC: begin
        if (icu_jmp) begin
          w_pc_next = r_ir_operand;
`ifdef ICU_CALL_STACK_EN
          w_push    = r_call_pending;
`endif
        end else if (icu_rtn) begin
`ifdef ICU_CALL_STACK_EN
          w_pop     = 1'b1;
          w_pc_next = w_stack_empty ? w_pc_inc : w_stack_top;
`else
          w_pc_next = w_pc_inc;
`endif
        end else begin
          w_pc_next = w_pc_inc;
        end
        w_next_state = (icu_flag_o || !r_run_q) ? S_IDLE : S_FETCH;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_req        <= 1'b0;
      r_ir_op      <= NOPO;
      r_ir_operand <= '0;
      r_run_q      <= 1'b1;
      r_run_qq     <= 1'b1;
      r_ack_meta   <= 1'b0;
      r_ack_sync   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_pc       <= w_pc_next;
      // Request is a flop driven from next state, so it changes with the state register.
      r_req      <= (w_next_state == S_REQ);
      r_run_q    <= run;
      r_run_qq   <= r_run_q;
      r_ack_meta <= icu_ack;
      r_ack_sync <= r_ack_meta;
      if (r_state == S_MEM) begin
        r_ir_op      <= instruction_t'(prog_data[OPCODE_W+ADDR_W-1:ADDR_W]);
        r_ir_operand <= prog_data[ADDR_W-1:0];
      end
    end
  end

  assign prog_en         = (r_state == S_FETCH);
  assign prog_addr       = r_pc;
  assign icu_req         = r_req;
  assign icu_instruction = r_ir_op;
  assign io_addr         = r_ir_operand;
  assign halted          = (r_state == S_IDLE);

`ifdef ICU_CALL_STACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_call_pending <= 1'b0;
      r_stack_err    <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_call_pending <= icu_flag_f;
      if ((w_push && w_stack_full) || (w_pop && w_stack_empty)) begin
        r_stack_err <= 1'b1;
      end
    end
  end

  assign stack_err = r_stack_err;

  icu_call_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_call_stack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (r_pc),
    .o_top   (w_stack_top),
    .o_full  (w_stack_full),
    .o_empty (w_stack_empty)
  );
`else
  logic w_unused_nostack;
  assign w_unused_nostack = icu_flag_f | (STACK_DEPTH == 0);
  assign stack_err        = 1'b0;
`endif

endmodule
